// File: rtl/uart_rx_ctrl_if.sv
// Bus bundle between the UART receive controller and its host/receiver.
// The master side drives receiver bytes, configuration and FIFO reads;
// the slave side (the controller) returns configuration, FIFO status and irq.
interface uart_rx_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_data_ready;
  logic       cfg_we;
  logic [7:0] cfg_wdata;
  logic [1:0] parity_mode;
  logic [1:0] stop_bit;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [3:0] level;
  logic       overflow;
  logic       ovf_clr;
  logic       irq;

  modport master (
    output rx_data, rx_data_ready, cfg_we, cfg_wdata, rd_en, ovf_clr,
    input  parity_mode, stop_bit, rd_data, rd_valid, level, overflow, irq
  );

  modport slave (
    input  rx_data, rx_data_ready, cfg_we, cfg_wdata, rd_en, ovf_clr,
    output parity_mode, stop_bit, rd_data, rd_valid, level, overflow, irq
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: captures bytes from the receiver on the rising
// edge of rx_data_ready into a first-word-fall-through FIFO, holds the
// receiver configuration, and raises a level interrupt on threshold,
// idle timeout or overflow.
module uart_rx_ctrl #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_ctrl_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [TW-1:0] TMR_ONE   = TW'(1);
  localparam logic [TW-1:0] TMR_SAT   = TW'(TIMEOUT);
  localparam logic [3:0]    DEPTH_LVL = 4'(DEPTH);

  typedef enum logic [1:0] {
    ST_OFF = 2'd0,
    ST_RUN = 2'd1,
    ST_TMO = 2'd2
  } state_e;

  state_e          state_r;
  state_e          state_s;
  logic            rdy_q_r;
  logic [7:0]      mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [3:0]      level_r;
  logic [TW-1:0]   timer_r;
  logic            overflow_r;
  logic            irq_r;
  logic [1:0]      parity_mode_r;
  logic [1:0]      stop_bit_r;
  logic [2:0]      threshold_r;
  logic            rx_en_r;

  logic            push_s;
  logic            pop_s;
  logic            wr_s;
  logic            drop_s;
  logic            empty_s;
  logic            full_s;
  logic            flush_s;
  logic            timer_clr_s;
  logic [3:0]      thr_plus_s;
  logic            irq_s;

  // A new byte is the 0->1 edge of the ready level, only while enabled.
  assign push_s      = bus.rx_data_ready & ~rdy_q_r & rx_en_r;
  assign empty_s     = (level_r == 4'd0);
  assign full_s      = (level_r == DEPTH_LVL);
  assign pop_s       = bus.rd_en & ~empty_s;
  // A push into a full FIFO still lands when the head leaves the same cycle.
  assign wr_s        = push_s & (~full_s | pop_s);
  assign drop_s      = push_s & full_s & ~pop_s;
  assign flush_s     = bus.cfg_we & ~bus.cfg_wdata[7];
  assign timer_clr_s = push_s | pop_s | empty_s | (state_r == ST_OFF);
  assign thr_plus_s  = {1'b0, threshold_r} + 4'd1;
  assign irq_s       = overflow_r
                     | (rx_en_r & ((level_r >= thr_plus_s) | (state_r == ST_TMO)));

  assign bus.rd_valid    = ~empty_s;
  assign bus.rd_data     = empty_s ? 8'h00 : mem_r[rd_ptr_r];
  assign bus.level       = level_r;
  assign bus.overflow    = overflow_r;
  assign bus.irq         = irq_r;
  assign bus.parity_mode = parity_mode_r;
  assign bus.stop_bit    = stop_bit_r;

  // Ready-level history; starts high so a level held through reset is no edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_q_r <= 1'b1;
    end else begin
      rdy_q_r <= bus.rx_data_ready;
    end
  end

  // Configuration register written by the host.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_mode_r <= 2'd0;
      stop_bit_r    <= 2'd1;
      threshold_r   <= 3'd0;
      rx_en_r       <= 1'b0;
    end else if (bus.cfg_we) begin
      parity_mode_r <= bus.cfg_wdata[1:0];
      stop_bit_r    <= bus.cfg_wdata[3:2];
      threshold_r   <= bus.cfg_wdata[6:4];
      rx_en_r       <= bus.cfg_wdata[7];
    end else begin
      parity_mode_r <= parity_mode_r;
      stop_bit_r    <= stop_bit_r;
      threshold_r   <= threshold_r;
      rx_en_r       <= rx_en_r;
    end
  end

  // FIFO storage; contents need no reset since level gates visibility.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[wr_ptr_r] <= bus.rx_data;
    end
  end

  // FIFO pointers and occupancy; disabling the receiver flushes the queue.
  always_ff @(posedge clk) begin
    if (rst || flush_s) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= 4'd0;
    end else begin
      if (wr_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({wr_s, pop_s})
        2'b10:   level_r <= level_r + 4'd1;
        2'b01:   level_r <= level_r - 4'd1;
        default: level_r <= level_r;
      endcase
    end
  end

  // Idle timer counts cycles with data pending and no traffic, saturating.
  always_ff @(posedge clk) begin
    if (rst || flush_s || timer_clr_s) begin
      timer_r <= '0;
    end else if (timer_r != TMR_SAT) begin
      timer_r <= timer_r + TMR_ONE;
    end else begin
      timer_r <= timer_r;
    end
  end

  // Sticky overflow; a drop wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else if (bus.ovf_clr) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_OFF;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: enable gates everything, timeout leaves on any traffic.
  always_comb begin
    state_s = state_r;
    if (!rx_en_r) begin
      state_s = ST_OFF;
    end else begin
      case (state_r)
        ST_OFF: state_s = ST_RUN;
        ST_RUN: begin
          if ((timer_r == TMR_SAT) && !(push_s || pop_s)) begin
            state_s = ST_TMO;
          end else begin
            state_s = ST_RUN;
          end
        end
        ST_TMO: begin
          if (push_s || pop_s) begin
            state_s = ST_RUN;
          end else begin
            state_s = ST_TMO;
          end
        end
        default: state_s = ST_OFF;
      endcase
    end
  end

  // Registered interrupt, one cycle behind its cause.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= irq_s;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl (DEPTH=8, TIMEOUT=64).
module tb_uart_rx_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  uart_rx_ctrl_if bus ();

  uart_rx_ctrl #(.DEPTH(8), .TIMEOUT(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] d);
    bus.rx_data       = d;
    bus.rx_data_ready = 1'b1;
    tick();
    bus.rx_data_ready = 1'b0;
    tick();
  endtask

  task automatic pop_one();
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic cfg_write(input logic [7:0] v);
    bus.cfg_we    = 1'b1;
    bus.cfg_wdata = v;
    tick();
    bus.cfg_we    = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst               = 1'b1;
    bus.rx_data       = 8'h00;
    bus.rx_data_ready = 1'b1;
    bus.cfg_we        = 1'b0;
    bus.cfg_wdata     = 8'h00;
    bus.rd_en         = 1'b0;
    bus.ovf_clr       = 1'b0;
    tick();
    tick();

    // Reset values, with ready held high through reset
    check("rst_parity",   32'(bus.parity_mode), 32'd0);
    check("rst_stop",     32'(bus.stop_bit),    32'd1);
    check("rst_level",    32'(bus.level),       32'd0);
    check("rst_rd_valid", 32'(bus.rd_valid),    32'd0);
    check("rst_rd_data",  32'(bus.rd_data),     32'h00);
    check("rst_overflow", 32'(bus.overflow),    32'd0);
    check("rst_irq",      32'(bus.irq),         32'd0);

    rst = 1'b0;
    cfg_write(8'h84);
    tick();
    check("held_rdy_no_push", 32'(bus.level), 32'd0);
    check("cfg_stop",         32'(bus.stop_bit), 32'd1);
    bus.rx_data_ready = 1'b0;
    tick();

    // Single byte round trip
    push_byte(8'hA5);
    check("one_level",    32'(bus.level),    32'd1);
    check("one_rd_valid", 32'(bus.rd_valid), 32'd1);
    check("one_rd_data",  32'(bus.rd_data),  32'hA5);
    check("one_irq",      32'(bus.irq),      32'd1);
    pop_one();
    check("one_pop_level", 32'(bus.level), 32'd0);
    tick();
    check("one_pop_irq",   32'(bus.irq),   32'd0);

    // Ready held high 20 cycles gives exactly one push
    bus.rx_data       = 8'h3C;
    bus.rx_data_ready = 1'b1;
    repeat (20) tick();
    bus.rx_data_ready = 1'b0;
    tick();
    check("hold_level", 32'(bus.level),   32'd1);
    check("hold_data",  32'(bus.rd_data), 32'h3C);
    pop_one();
    check("hold_pop_level", 32'(bus.level), 32'd0);

    // Overflow: nine pushes, no reads
    for (int i = 0; i < 9; i++) push_byte(8'h10 + 8'(i));
    check("ovf_level", 32'(bus.level),    32'd8);
    check("ovf_flag",  32'(bus.overflow), 32'd1);
    check("ovf_irq",   32'(bus.irq),      32'd1);
    for (int i = 0; i < 8; i++) begin
      check("ovf_order", 32'(bus.rd_data), 32'h10 + 32'(i));
      pop_one();
    end
    check("ovf_empty_valid", 32'(bus.rd_valid), 32'd0);
    check("ovf_empty_data",  32'(bus.rd_data),  32'h00);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("ovf_clr", 32'(bus.overflow), 32'd0);
    tick();
    check("ovf_clr_irq", 32'(bus.irq), 32'd0);

    // Pop on empty is ignored
    pop_one();
    check("empty_pop_level", 32'(bus.level), 32'd0);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) push_byte(8'h20 + 8'(i));
    check("full_level", 32'(bus.level), 32'd8);
    bus.rx_data       = 8'hEE;
    bus.rx_data_ready = 1'b1;
    bus.rd_en         = 1'b1;
    tick();
    bus.rx_data_ready = 1'b0;
    bus.rd_en         = 1'b0;
    tick();
    check("pp_level",    32'(bus.level),    32'd8);
    check("pp_overflow", 32'(bus.overflow), 32'd0);
    for (int i = 1; i < 8; i++) begin
      check("pp_order", 32'(bus.rd_data), 32'h20 + 32'(i));
      pop_one();
    end
    check("pp_last", 32'(bus.rd_data), 32'hEE);
    pop_one();
    check("pp_drained", 32'(bus.level), 32'd0);

    // Threshold 3 and idle timeout
    cfg_write(8'hB4);
    push_byte(8'h31);
    push_byte(8'h32);
    check("thr_level",   32'(bus.level), 32'd2);
    check("thr_irq_low", 32'(bus.irq),   32'd0);
    repeat (64) tick();
    check("tmo_not_yet", 32'(bus.irq), 32'd0);
    tick();
    check("tmo_irq", 32'(bus.irq), 32'd1);
    pop_one();
    tick();
    check("tmo_pop_irq",   32'(bus.irq),     32'd0);
    check("tmo_pop_data",  32'(bus.rd_data), 32'h32);

    // Level 5 then disable flushes the FIFO
    for (int i = 0; i < 4; i++) push_byte(8'h40 + 8'(i));
    check("l5_level", 32'(bus.level), 32'd5);
    check("l5_irq",   32'(bus.irq),   32'd1);
    cfg_write(8'h04);
    check("dis_level",    32'(bus.level),    32'd0);
    check("dis_rd_valid", 32'(bus.rd_valid), 32'd0);
    tick();
    check("dis_irq",      32'(bus.irq),      32'd0);
    check("dis_overflow", 32'(bus.overflow), 32'd0);
    push_byte(8'h77);
    check("dis_no_push", 32'(bus.level), 32'd0);

    // Re-enable after flush: pointers restart cleanly
    cfg_write(8'h84);
    tick();
    push_byte(8'h5A);
    check("reen_level", 32'(bus.level),   32'd1);
    check("reen_data",  32'(bus.rd_data), 32'h5A);

    // Reset in the middle of operation
    push_byte(8'h5B);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_level", 32'(bus.level),    32'd0);
    check("mid_rst_valid", 32'(bus.rd_valid), 32'd0);
    check("mid_rst_irq",   32'(bus.irq),      32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
